// File: rtl/write_uart.sv
// write_uart: 8N1/8N2 UART transmitter fed by a small valid/ready byte FIFO.
// Bit period is freq+1 clocks, matching the receive side's timing convention.
module write_uart #(
   parameter int freq      = 347,
   parameter int fifo_aw   = 2,
   parameter int stop_bits = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         data,
   input  logic               valid,
   output logic               ready,
   output logic               TxD,
   output logic               busy,
   output logic [fifo_aw:0]   level
);
   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_start = 2'd1;
   localparam logic [1:0] st_data  = 2'd2;
   localparam logic [1:0] st_stop  = 2'd3;
   localparam int tw = $clog2(stop_bits * (freq + 1) + 1);
   localparam logic [tw-1:0] bit_end  = tw'(freq);
   localparam logic [tw-1:0] stop_end = tw'(stop_bits * (freq + 1) - 1);
   localparam logic [fifo_aw:0] depth = (fifo_aw + 1)'(2 ** fifo_aw);

   logic [7:0]         mem [2**fifo_aw];
   logic [fifo_aw-1:0] wp, rp;
   logic [1:0]         state, state_n;
   logic [tw-1:0]      timer, timer_n;
   logic [2:0]         idx, idx_n;
   logic [7:0]         sh, sh_n;
   logic               txd_n, push, pop;
   logic [fifo_aw:0]   level_n;

   assign ready   = level != depth;
   assign push    = valid && ready;
   // A frame starts from IDLE or straight out of the last stop-bit cycle, so queued bytes go out gap-free
   assign pop     = (level != '0) && (state == st_idle || (state == st_stop && timer == stop_end));
   assign level_n = level + (fifo_aw + 1)'(push) - (fifo_aw + 1)'(pop);

   always_comb begin
      state_n = state;
      timer_n = timer + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      txd_n   = TxD;
      if (pop) begin
         state_n = st_start;
         timer_n = '0;
         sh_n    = mem[rp];
         txd_n   = 1'b0;
      end else case (state)
         st_idle: timer_n = '0;
         st_start: if (timer == bit_end) begin
            state_n = st_data;
            timer_n = '0;
            idx_n   = '0;
            txd_n   = sh[0];
            sh_n    = {1'b0, sh[7:1]};
         end
         st_data: if (timer == bit_end) begin
            timer_n = '0;
            if (idx == 3'd7) begin
               state_n = st_stop;
               txd_n   = 1'b1;
            end else begin
               idx_n = idx + 3'd1;
               txd_n = sh[0];
               sh_n  = {1'b0, sh[7:1]};
            end
         end
         st_stop: if (timer == stop_end) begin
            state_n = st_idle;
            timer_n = '0;
         end
         default: state_n = st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= st_idle;
         timer <= '0;
         idx   <= '0;
         sh    <= '0;
         TxD   <= 1'b1;
         busy  <= 1'b0;
         level <= '0;
         wp    <= '0;
         rp    <= '0;
      end else begin
         state <= state_n;
         timer <= timer_n;
         idx   <= idx_n;
         sh    <= sh_n;
         TxD   <= txd_n;
         busy  <= (state_n != st_idle) || (level_n != '0);
         level <= level_n;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end

   always_ff @(posedge clk)
      if (push) mem[wp] <= data;
endmodule

// File: tb/tb_write_uart.sv
// tb_write_uart: directed bench for write_uart at freq=3 with one and two stop bits.
module tb_write_uart;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] data = '0, data2 = '0;
   logic       valid = 1'b0, valid2 = 1'b0;
   logic       ready, TxD, busy, ready2, txd2, busy2;
   logic [2:0] level, level2;
   int         checks = 0, errors = 0;
   logic [7:0] fb [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   int         fl [5] = '{3, 2, 1, 0, 0};

   write_uart #(.freq(3), .fifo_aw(2), .stop_bits(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready),
      .TxD(TxD), .busy(busy), .level(level));
   write_uart #(.freq(3), .fifo_aw(2), .stop_bits(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data(data2), .valid(valid2), .ready(ready2),
      .TxD(txd2), .busy(busy2), .level(level2));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Walks one frame from cycle k0 (0 = first start-bit cycle), checking every TxD cycle and decoding mid-bit.
   task automatic frame(input string tag, input logic [7:0] b, input bit two, input int k0);
      logic [7:0] rx;
      logic       t, e;
      int         n, j;
      rx = '0;
      n = two ? 44 : 40;
      for (int k = k0; k < n; k++) begin
         t = two ? txd2 : TxD;
         j = (k - 4) / 4;
         if (k < 4) e = 1'b0;
         else if (k < 36) e = b[3'(j)];
         else e = 1'b1;
         check($sformatf("%s k%0d", tag, k), 32'(t), 32'(e));
         if (k >= 4 && k < 36 && (k % 4) == 2) rx[3'(j)] = t;
         if (k == n - 1) check({tag, " busy_end"}, 32'(two ? busy2 : busy), 1);
         tick();
      end
      check({tag, " rx"}, 32'(rx), 32'(b));
   endtask

   initial begin
      repeat (3) tick();
      check("rst", 32'({TxD, ready, busy, level}), 'h30);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         check("idle", 32'({TxD, ready, busy, level}), 'h30);
         tick();
      end

      data = 8'hA5; valid = 1'b1; tick();
      valid = 1'b0;
      check("a5 level", 32'(level), 1);
      check("a5 busy", 32'(busy), 1);
      check("a5 txd", 32'(TxD), 1);
      tick();
      frame("a5", 8'hA5, 1'b0, 0);
      check("a5 done", 32'({TxD, busy, level}), 'h10);

      data = 8'h00; valid = 1'b1; tick();
      check("b2b lvl0", 32'(level), 1);
      data = 8'hFF; tick();
      check("b2b lvl1", 32'(level), 1);
      check("b2b start", 32'(TxD), 0);
      data = 8'h3C; tick();
      valid = 1'b0;
      check("b2b peak", 32'(level), 2);
      frame("b00", 8'h00, 1'b0, 1);
      check("b2b lvl2", 32'(level), 1);
      frame("bff", 8'hFF, 1'b0, 0);
      check("b2b lvl3", 32'(level), 0);
      frame("b3c", 8'h3C, 1'b0, 0);
      check("b2b done", 32'({TxD, busy, level}), 'h10);

      for (int i = 0; i < 6; i++) begin
         data = fb[i]; valid = 1'b1;
         if (i == 5) begin
            check("full ready", 32'(ready), 0);
            check("full level", 32'(level), 4);
         end
         tick();
      end
      valid = 1'b0;
      check("full hold", 32'(level), 4);
      for (int i = 0; i < 5; i++) begin
         frame($sformatf("full%0d", i), fb[i], 1'b0, i == 0 ? 4 : 0);
         check($sformatf("full lvl%0d", i), 32'(level), 32'(fl[i]));
      end
      check("full done", 32'({TxD, busy}), 'h2);
      for (int i = 0; i < 20; i++) begin
         check("no 6th", 32'({TxD, busy, level}), 'h10);
         tick();
      end

      data2 = 8'h55; valid2 = 1'b1; tick();
      valid2 = 1'b0;
      check("s2 busy", 32'(busy2), 1);
      tick();
      frame("s2", 8'h55, 1'b1, 0);
      check("s2 done", 32'({txd2, busy2, level2}), 'h10);

      data = 8'h81; valid = 1'b1; tick();
      data = 8'h12; tick();
      data = 8'h34; tick();
      valid = 1'b0;
      repeat (16) tick();
      check("mid bit3", 32'(TxD), 0);
      check("mid level", 32'(level), 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst", 32'({TxD, ready, busy, level}), 'h30);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         check("post rst", 32'({TxD, busy, level}), 'h10);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
